// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: shares the SDRAM controller request port between CPU and video fetch,
// video-first with CPU starvation relief and a ready watchdog.
module sdram_req_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int CPU_WAIT_MAX = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic              cpu_ready,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_ready,
    output logic [DATA_W-1:0] rd_dout,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,
    output logic              owner_vid,
    output logic              err_timeout
);
    localparam logic [3:0] WAIT_MAX = 4'(CPU_WAIT_MAX);
    localparam logic [7:0] WD_MAX   = 8'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] wd_cnt;
    logic       grant_any, grant_vid;
    always_comb begin
        grant_any = !mem_busy && (cpu_req || vid_req);
        grant_vid = vid_req && !(cpu_req && starve_cnt >= WAIT_MAX);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            mem_req     <= 1'b0;
            mem_rnw     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            owner_vid   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_ready   <= 1'b0;
            vid_ack     <= 1'b0;
            vid_ready   <= 1'b0;
            rd_dout     <= '0;
            err_timeout <= 1'b0;
        end else begin
            cpu_ack     <= 1'b0;
            cpu_ready   <= 1'b0;
            vid_ack     <= 1'b0;
            vid_ready   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (grant_any) begin
                    state      <= ISSUE;
                    mem_req    <= 1'b1;
                    owner_vid  <= grant_vid;
                    mem_rnw    <= grant_vid || cpu_rnw;
                    mem_addr   <= grant_vid ? vid_addr : cpu_addr;
                    mem_din    <= grant_vid ? 8'h00 : cpu_din;
                    starve_cnt <= !grant_vid ? 4'd0 :
                                  (cpu_req && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
                end
                ISSUE: if (mem_ack) begin
                    mem_req <= 1'b0;
                    wd_cnt  <= '0;
                    cpu_ack <= !owner_vid;
                    vid_ack <= owner_vid;
                    state   <= DATA;
                    // a controller may finish in the same cycle it accepts
                    if (mem_ready) begin
                        rd_dout   <= mem_dout;
                        cpu_ready <= !owner_vid;
                        vid_ready <= owner_vid;
                        state     <= IDLE;
                    end
                end
                DATA: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (mem_ready || wd_cnt == WD_MAX) begin
                        rd_dout     <= mem_ready ? mem_dout : '0;
                        cpu_ready   <= !owner_vid;
                        vid_ready   <= owner_vid;
                        err_timeout <= !mem_ready;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
